dtw_sync_fifo: RTL

//  Parametrised single-clock circular-buffer FIFO; successor to the DTW shift-queue FIFO.

---
 rtl/dtw_sync_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dtw_sync_fifo.sv
// Single-clock circular-buffer FIFO between DTW pipeline stages, with occupancy
// count, almost-full/empty flags and sticky error flags. Define DTW_FIFO_PEAK_EN for the peak-occupancy monitor.
module dtw_sync_fifo #(
    parameter int  DEPTH      = 15,
    parameter int  DATA_WIDTH = 32,
    parameter int  AF_THRESH  = 12,
    parameter int  AE_THRESH  = 2,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic [CW-1:0]         peak
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_ok, wr_ok, mem_we;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign o_data       = o_data_q;
    assign o_valid      = o_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
    always_comb begin
        rd_ok       = rden & ~empty;
        wr_ok       = wren & (~full | rd_ok);
        mem_we      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        o_data_d    = o_data_q;
        o_valid_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (rd_ok) begin
                rd_ptr_d  = next_ptr(rd_ptr_q);
                o_data_d  = mem[rd_ptr_q];
                o_valid_d = 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
            if (clr_err) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (wren && !wr_ok) overflow_d  = 1'b1;
            if (rden && !rd_ok) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= i_data;
    end

`ifdef DTW_FIFO_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule
